// File: rtl/turn_signal_seq.sv
// Turn-signal sequencer: maps stalk/hazard levels to 3-lamp sweep patterns
// on l_signal/r_signal, one lamp step every TICK_DIV clocks.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no request, lamps dark, prescaler parked at 0
// L1..L3 | left sweep, 1/2/3 lamps lit (inner to outer)
// L0     | left sweep dark gap before the ring restarts
// R1..R3 | right sweep, mirror of L1..L3 on r_signal
// R0     | right sweep dark gap
// HON    | hazard, all six lamps lit
// HOFF   | hazard, all lamps dark
module turn_signal_seq #(
  parameter int TICK_DIV = 4,
  localparam int CNT_W = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard,
  output logic [2:0] l_signal,
  output logic [2:0] r_signal,
  output logic       active
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_L1   = 4'd1;
  localparam logic [3:0] S_L2   = 4'd2;
  localparam logic [3:0] S_L3   = 4'd3;
  localparam logic [3:0] S_L0   = 4'd4;
  localparam logic [3:0] S_R1   = 4'd5;
  localparam logic [3:0] S_R2   = 4'd6;
  localparam logic [3:0] S_R3   = 4'd7;
  localparam logic [3:0] S_R0   = 4'd8;
  localparam logic [3:0] S_HON  = 4'd9;
  localparam logic [3:0] S_HOFF = 4'd10;

  localparam logic [1:0] REQ_NONE  = 2'd0;
  localparam logic [1:0] REQ_LEFT  = 2'd1;
  localparam logic [1:0] REQ_RIGHT = 2'd2;
  localparam logic [1:0] REQ_HAZ   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("turn_signal_seq: TICK_DIV must be at least 2");
    end
  endgenerate

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_nxt;
  logic [1:0]       req;
  logic             tick;
  logic [2:0]       l_nxt;
  logic [2:0]       r_nxt;

  // Both stalks at once is treated as a hazard request.
  always_comb begin
    if (hazard || (left_req && right_req)) req = REQ_HAZ;
    else if (left_req)                     req = REQ_LEFT;
    else if (right_req)                    req = REQ_RIGHT;
    else                                   req = REQ_NONE;
  end

  assign tick = (state != S_IDLE) && (presc == CNT_LAST);

  function automatic logic [3:0] l_ring_next(input logic [3:0] s);
    case (s)
      S_L1:    return S_L2;
      S_L2:    return S_L3;
      S_L3:    return S_L0;
      default: return S_L1;
    endcase
  endfunction

  function automatic logic [3:0] r_ring_next(input logic [3:0] s);
    case (s)
      S_R1:    return S_R2;
      S_R2:    return S_R3;
      S_R3:    return S_R0;
      default: return S_R1;
    endcase
  endfunction

  // IDLE reacts on any edge; every other state only moves on a tick.
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      case (req)
        REQ_HAZ:   state_nxt = S_HON;
        REQ_LEFT:  state_nxt = S_L1;
        REQ_RIGHT: state_nxt = S_R1;
        default:   state_nxt = S_IDLE;
      endcase
    end else if (tick) begin
      case (req)
        REQ_HAZ:   state_nxt = (state == S_HON) ? S_HOFF : S_HON;
        REQ_LEFT:  state_nxt = l_ring_next(state);
        REQ_RIGHT: state_nxt = r_ring_next(state);
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign presc_nxt = ((state == S_IDLE) || tick) ? '0 : presc + CNT_W'(1);

  always_comb begin
    l_nxt = 3'b000;
    r_nxt = 3'b000;
    case (state_nxt)
      S_L1:    l_nxt = 3'b001;
      S_L2:    l_nxt = 3'b011;
      S_L3:    l_nxt = 3'b111;
      S_R1:    r_nxt = 3'b001;
      S_R2:    r_nxt = 3'b011;
      S_R3:    r_nxt = 3'b111;
      S_HON: begin
        l_nxt = 3'b111;
        r_nxt = 3'b111;
      end
      default: begin
        l_nxt = 3'b000;
        r_nxt = 3'b000;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      l_signal <= 3'b000;
      r_signal <= 3'b000;
      active   <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      l_signal <= l_nxt;
      r_signal <= r_nxt;
      active   <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: directed waveform pins plus randomized stalk/hazard
// activity checked every cycle against a step-counting lamp model.
module tb_turn_signal_seq;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       hazard = 1'b0;
  logic [2:0] l_signal;
  logic [2:0] r_signal;
  logic       active;

  int n_checks = 0;
  int n_fail = 0;

  // kind: 0 none, 1 left, 2 right, 3 hazard; step counts lamp steps in a run
  int m_kind = 0;
  int m_step = 0;
  int m_age = 0;

  logic [2:0] sweep [4];

  turn_signal_seq #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .left_req(left_req),
    .right_req(right_req),
    .hazard(hazard),
    .l_signal(l_signal),
    .r_signal(r_signal),
    .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    sweep[0] = 3'b001;
    sweep[1] = 3'b011;
    sweep[2] = 3'b111;
    sweep[3] = 3'b000;
  end

  function automatic int req_kind(input logic l, input logic r, input logic h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] exp_l(input int kind, input int step);
    if (kind == 1) return sweep[step % 4];
    if (kind == 3) return (step % 2 == 0) ? 3'b111 : 3'b000;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_r(input int kind, input int step);
    if (kind == 2) return sweep[step % 4];
    if (kind == 3) return (step % 2 == 0) ? 3'b111 : 3'b000;
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int q, k, s, a;
    if (rst) begin
      m_kind <= 0;
      m_step <= 0;
      m_age  <= 0;
    end else begin
      q = req_kind(left_req, right_req, hazard);
      k = m_kind;
      s = m_step;
      a = m_age;
      if (k == 0) begin
        k = q;
        s = 0;
        a = 0;
      end else begin
        a = a + 1;
        if (a == TICK_DIV) begin
          a = 0;
          if (q == k) s = s + 1;
          else begin
            k = q;
            s = 0;
          end
        end
      end
      m_kind <= k;
      m_step <= s;
      m_age  <= a;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_l", l_signal, exp_l(m_kind, m_step));
      chk("model_r", r_signal, exp_r(m_kind, m_step));
      chk("model_active", {2'b00, active}, {2'b00, (m_kind != 0)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    step();
    left_req = 1'b0;
    right_req = 1'b0;
    hazard = 1'b0;
    repeat (3 * TICK_DIV) step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_l", l_signal, 3'b000);
    chk("reset_r", r_signal, 3'b000);
    chk("reset_active", {2'b00, active}, 3'b000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_l", l_signal, 3'b000);
    chk("idle_active", {2'b00, active}, 3'b000);

    // left held: 001 x4, 011 x4, 111 x4, 000 x4, then 001
    step();
    left_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("left_ring_l", l_signal,
          (k <= 4) ? 3'b001 : (k <= 8) ? 3'b011 : (k <= 12) ? 3'b111 :
          (k <= 16) ? 3'b000 : 3'b001);
      chk("left_ring_r", r_signal, 3'b000);
    end
    quiesce();

    // async reset mid-L2
    step();
    left_req = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_l2", l_signal, 3'b011);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_l", l_signal, 3'b000);
    chk("async_rst_r", r_signal, 3'b000);
    chk("async_rst_active", {2'b00, active}, 3'b000);
    left_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_l", l_signal, 3'b000);
      chk("post_rst_active", {2'b00, active}, 3'b000);
    end

    // 1-cycle left pulse from IDLE
    step();
    left_req = 1'b1;
    @(posedge clk);
    #1;
    left_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("pulse_l", l_signal, (k <= 4) ? 3'b001 : 3'b000);
      chk("pulse_active", {2'b00, active}, {2'b00, (k <= 4)});
    end
    quiesce();

    // left released one cycle into L2
    step();
    left_req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    left_req = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      @(negedge clk);
      chk("release_l", l_signal, (k <= 8) ? 3'b011 : 3'b000);
      chk("release_active", {2'b00, active}, {2'b00, (k <= 8)});
    end
    quiesce();

    // hazard switch, then both stalks: same blink
    for (int mode = 0; mode < 2; mode++) begin
      step();
      if (mode == 0) hazard = 1'b1;
      else begin
        left_req = 1'b1;
        right_req = 1'b1;
      end
      @(posedge clk);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        chk("haz_l", l_signal, (((k - 1) / 4) % 2 == 0) ? 3'b111 : 3'b000);
        chk("haz_r", r_signal, (((k - 1) / 4) % 2 == 0) ? 3'b111 : 3'b000);
        chk("haz_active", {2'b00, active}, 3'b001);
      end
      quiesce();
    end

    // direction change during L3
    step();
    left_req = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    left_req = 1'b0;
    right_req = 1'b1;
    for (int k = 10; k <= 13; k++) begin
      @(negedge clk);
      chk("dir_l", l_signal, (k <= 12) ? 3'b111 : 3'b000);
      chk("dir_r", r_signal, (k <= 12) ? 3'b000 : 3'b001);
    end
    quiesce();

    // hazard during R2, then dropped while right held
    step();
    right_req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    hazard = 1'b1;
    for (int k = 6; k <= 13; k++) begin
      @(negedge clk);
      chk("hzr_l", l_signal, (k <= 8 || k == 13) ? 3'b000 : 3'b111);
      chk("hzr_r", r_signal, (k <= 8) ? 3'b011 : (k <= 12) ? 3'b111 : 3'b001);
      if (k == 9) hazard = 1'b0;
    end
    quiesce();

    // randomized activity including occasional resets
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) left_req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) right_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) hazard = ($urandom_range(0, 3) == 0);
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
